// File: rtl/hazard_detect_pkg.sv
// Shared pipeline definitions: opcode constants, hazard codes and the producer
// record used by the hazard detector and the forwarding unit.
package hazard_detect_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] HZ_NONE    = 3'd0;
  localparam logic [2:0] HZ_EX_RS1  = 3'd1;
  localparam logic [2:0] HZ_EX_RS2  = 3'd2;
  localparam logic [2:0] HZ_MEM_RS1 = 3'd3;
  localparam logic [2:0] HZ_MEM_RS2 = 3'd4;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } prod_rec_t;

  localparam prod_rec_t REC_BUBBLE = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};

  // x0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic rec_match(input prod_rec_t rec, input logic used,
                                     input logic [4:0] src);
    return rec.wr && (rec.rd != 5'd0) && used && (src == rec.rd);
  endfunction

endpackage

// File: rtl/hazard_detect_decode.sv
// Opcode classification for the hazard detector: which register fields an
// instruction reads and whether it writes rd or is a load.
module hazard_decode
  import hazard_detect_pkg::*;
(
  input  logic [6:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  // Unknown opcodes are treated conservatively as rs1 readers and rd writers.
  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b1;
    is_load   = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
      OPC_OP:                      uses_rs2 = 1'b1;
      OPC_STORE, OPC_BRANCH: begin
        uses_rs2  = 1'b1;
        writes_rd = 1'b0;
      end
      OPC_LOAD:                    is_load = 1'b1;
      default:                     uses_rs1 = 1'b1;
    endcase
  end

endmodule

// File: rtl/hazard_detect.sv
// Data-hazard detector: tracks the two producers ahead of ID, flags EX/MEM
// dependencies one cycle later and stalls one cycle on a load-use.
module hazard_detect
  import hazard_detect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] id_op,
  input  logic [4:0] id_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       redirect,
  output logic       stall,
  output logic       is_hazard1,
  output logic [2:0] hazard_reg1,
  output logic       is_hazard2,
  output logic [2:0] hazard_reg2,
  output logic       ex_is_bubble
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [0:0] state_r;
  prod_rec_t  ex_rec_r;
  prod_rec_t  mem_rec_r;

  logic       uses_rs1_s;
  logic       uses_rs2_s;
  logic       writes_rd_s;
  logic       is_load_s;
  logic       advance_s;
  logic       ex_m1_s;
  logic       ex_m2_s;
  logic       mem_m1_s;
  logic       mem_m2_s;
  logic       stall_s;
  logic [2:0] hz1_s;
  logic [2:0] hz2_s;
  prod_rec_t  id_rec_s;

  hazard_decode u_decode (
    .op        (id_op),
    .uses_rs1  (uses_rs1_s),
    .uses_rs2  (uses_rs2_s),
    .writes_rd (writes_rd_s),
    .is_load   (is_load_s)
  );

  // Source matching, stall condition and next hazard codes; a redirect
  // squashes the ID instruction and therefore overrides any stall.
  always_comb begin
    advance_s   = id_valid && !redirect;
    ex_m1_s     = rec_match(ex_rec_r, uses_rs1_s, id_rs1);
    ex_m2_s     = rec_match(ex_rec_r, uses_rs2_s, id_rs2);
    mem_m1_s    = rec_match(mem_rec_r, uses_rs1_s, id_rs1);
    mem_m2_s    = rec_match(mem_rec_r, uses_rs2_s, id_rs2);
    stall_s     = advance_s && (state_r == ST_RUN) && ex_rec_r.ld && (ex_m1_s || ex_m2_s);
    id_rec_s.rd = id_rd;
    id_rec_s.wr = writes_rd_s;
    id_rec_s.ld = is_load_s;
    if (ex_m1_s) begin
      hz1_s = HZ_EX_RS1;
    end else if (ex_m2_s) begin
      hz1_s = HZ_EX_RS2;
    end else begin
      hz1_s = HZ_NONE;
    end
    if (mem_m1_s) begin
      hz2_s = HZ_MEM_RS1;
    end else if (mem_m2_s) begin
      hz2_s = HZ_MEM_RS2;
    end else begin
      hz2_s = HZ_NONE;
    end
  end

  assign stall = stall_s;

  // Producer records, FSM and the hazard outputs aligned with the ID/EX register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_RUN;
      ex_rec_r     <= REC_BUBBLE;
      mem_rec_r    <= REC_BUBBLE;
      is_hazard1   <= 1'b0;
      hazard_reg1  <= HZ_NONE;
      is_hazard2   <= 1'b0;
      hazard_reg2  <= HZ_NONE;
      ex_is_bubble <= 1'b1;
    end else begin
      mem_rec_r <= ex_rec_r;
      if (stall_s || !advance_s) begin
        state_r      <= stall_s ? ST_STALL : ST_RUN;
        ex_rec_r     <= REC_BUBBLE;
        is_hazard1   <= 1'b0;
        hazard_reg1  <= HZ_NONE;
        is_hazard2   <= 1'b0;
        hazard_reg2  <= HZ_NONE;
        ex_is_bubble <= 1'b1;
      end else begin
        state_r      <= ST_RUN;
        ex_rec_r     <= id_rec_s;
        is_hazard1   <= (hz1_s != HZ_NONE);
        hazard_reg1  <= hz1_s;
        is_hazard2   <= (hz2_s != HZ_NONE);
        hazard_reg2  <= hz2_s;
        ex_is_bubble <= 1'b0;
      end
    end
  end

endmodule
